// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Includes the per-operand Tnew/Tuse hazard test.
package pipe_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_EXC = 2'd1;
  localparam logic [1:0] PC_SEL_EPC = 2'd2;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } st_t;

  // A producer stalls D only if its result arrives after D needs it.
  function automatic logic hz_op(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic       e_wen,
    input logic [4:0] e_a3,
    input logic [1:0] e_tnew,
    input logic       m_wen,
    input logic [4:0] m_a3,
    input logic [1:0] m_tnew
  );
    logic w_e;
    logic w_m;
    w_e = e_wen && (e_a3 == addr) && (e_tnew > tuse);
    w_m = m_wen && (m_a3 == addr) && (m_tnew > tuse);
    return (addr != 5'd0) && (tuse != TUSE_NONE) && (w_e || w_m);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy counter: loads on start, counts down to zero.
// A start while busy reloads; busy includes the start cycle.
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [2:0] i_op,
  output logic       o_busy
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_div;

  assign w_div  = (i_op == MD_DIV) || (i_op == MD_DIVU);
  assign o_busy = (r_cnt != '0) || i_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= w_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// One prioritised decision per cycle drives all en/clr and PC control.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic       d_is_md,
  input  logic [4:0] e_a3,
  input  logic       e_reg_wen,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_a3,
  input  logic       m_reg_wen,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic [2:0] e_md_op,
  input  logic       m_dm_req,
  input  logic       m_dm_ack,
  input  logic       exc_req,
  input  logic       m_eret,
  output logic       pc_en,
  output logic [1:0] pc_sel,
  output logic       en_fd,
  output logic       en_de,
  output logic       en_em,
  output logic       en_mw,
  output logic       clr_fd,
  output logic       clr_de,
  output logic       clr_em,
  output logic       clr_mw,
  output logic       md_busy,
  output logic       stall
);

  st_t  r_st;
  st_t  w_st_nxt;
  logic w_busy;
  logic w_hz_rs;
  logic w_hz_rt;
  logic w_md_hz;
  logic w_memwait;
  logic w_row_exc;
  logic w_row_eret;
  logic w_row_mem;
  logic w_row_hz;

  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_md_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_start (e_md_start),
    .i_op    (e_md_op),
    .o_busy  (w_busy)
  );

  assign w_hz_rs = hz_op(d_rs_addr, d_rs_tuse,
                         e_reg_wen, e_a3, e_tnew,
                         m_reg_wen, m_a3, m_tnew);
  assign w_hz_rt = hz_op(d_rt_addr, d_rt_tuse,
                         e_reg_wen, e_a3, e_tnew,
                         m_reg_wen, m_a3, m_tnew);
  assign w_md_hz = d_is_md && w_busy;

  assign w_memwait = ~m_dm_ack &&
                     ((r_st == ST_MEMWAIT) || m_dm_req);

  // Rows made mutually exclusive so the decoder below is one-hot.
  assign w_row_exc  = ~reset && exc_req;
  assign w_row_eret = ~reset && ~exc_req && m_eret;
  assign w_row_mem  = ~reset && ~exc_req && ~m_eret && w_memwait;
  assign w_row_hz   = ~reset && ~exc_req && ~m_eret && ~w_memwait &&
                      (w_hz_rs || w_hz_rt || w_md_hz);

  assign md_busy = ~reset && w_busy;

  always_comb begin
    pc_en  = 1'b1;
    pc_sel = PC_SEL_SEQ;
    en_fd  = 1'b1;
    en_de  = 1'b1;
    en_em  = 1'b1;
    en_mw  = 1'b1;
    clr_fd = 1'b0;
    clr_de = 1'b0;
    clr_em = 1'b0;
    clr_mw = 1'b0;
    stall  = 1'b0;
    unique case (1'b1)
      reset: begin
        pc_en  = 1'b0;
        clr_fd = 1'b1;
        clr_de = 1'b1;
        clr_em = 1'b1;
        clr_mw = 1'b1;
      end
      w_row_exc: begin
        pc_sel = PC_SEL_EXC;
        clr_fd = 1'b1;
        clr_de = 1'b1;
        clr_em = 1'b1;
      end
      w_row_eret: begin
        pc_sel = PC_SEL_EPC;
        clr_fd = 1'b1;
        clr_de = 1'b1;
        clr_em = 1'b1;
      end
      w_row_mem: begin
        pc_en  = 1'b0;
        en_fd  = 1'b0;
        en_de  = 1'b0;
        en_em  = 1'b0;
        clr_mw = 1'b1;
        stall  = 1'b1;
      end
      w_row_hz: begin
        pc_en  = 1'b0;
        en_fd  = 1'b0;
        clr_de = 1'b1;
        stall  = 1'b1;
      end
      default: begin
        pc_en  = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_st_nxt = r_st;
    if (exc_req) begin
      w_st_nxt = ST_RUN;
    end else if (r_st == ST_RUN) begin
      if (m_dm_req && ~m_dm_ack) w_st_nxt = ST_MEMWAIT;
    end else if (m_dm_ack) begin
      w_st_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_st <= ST_RUN;
    else       r_st <= w_st_nxt;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl.
// Outputs are packed as {pc_en,pc_sel,en_fd..en_mw,clr_fd..clr_mw,md_busy,stall}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs_addr, d_rt_addr, e_a3, m_a3;
  logic [1:0] d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
  logic       d_is_md, e_reg_wen, m_reg_wen, e_md_start;
  logic [2:0] e_md_op;
  logic       m_dm_req, m_dm_ack, exc_req, m_eret;
  logic       pc_en, en_fd, en_de, en_em, en_mw;
  logic       clr_fd, clr_de, clr_em, clr_mw;
  logic       md_busy, stall;
  logic [1:0] pc_sel;
  logic [12:0] obs;

  int total = 0;
  int bad   = 0;

  localparam logic [12:0] V_RST  = 13'b0_00_1111_1111_0_0;
  localparam logic [12:0] V_NRM  = 13'b1_00_1111_0000_0_0;
  localparam logic [12:0] V_NRMB = 13'b1_00_1111_0000_1_0;
  localparam logic [12:0] V_HZ   = 13'b0_00_0111_0100_0_1;
  localparam logic [12:0] V_HZB  = 13'b0_00_0111_0100_1_1;
  localparam logic [12:0] V_MEM  = 13'b0_00_0001_0001_0_1;
  localparam logic [12:0] V_MEMB = 13'b0_00_0001_0001_1_1;
  localparam logic [12:0] V_EXCB = 13'b1_01_1111_1110_1_0;
  localparam logic [12:0] V_ERTB = 13'b1_10_1111_1110_1_0;

  always #5 clk = ~clk;

  assign obs = {pc_en, pc_sel, en_fd, en_de, en_em, en_mw,
                clr_fd, clr_de, clr_em, clr_mw, md_busy, stall};

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs_addr  (d_rs_addr),
    .d_rt_addr  (d_rt_addr),
    .d_rs_tuse  (d_rs_tuse),
    .d_rt_tuse  (d_rt_tuse),
    .d_is_md    (d_is_md),
    .e_a3       (e_a3),
    .e_reg_wen  (e_reg_wen),
    .e_tnew     (e_tnew),
    .m_a3       (m_a3),
    .m_reg_wen  (m_reg_wen),
    .m_tnew     (m_tnew),
    .e_md_start (e_md_start),
    .e_md_op    (e_md_op),
    .m_dm_req   (m_dm_req),
    .m_dm_ack   (m_dm_ack),
    .exc_req    (exc_req),
    .m_eret     (m_eret),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .en_fd      (en_fd),
    .en_de      (en_de),
    .en_em      (en_em),
    .en_mw      (en_mw),
    .clr_fd     (clr_fd),
    .clr_de     (clr_de),
    .clr_em     (clr_em),
    .clr_mw     (clr_mw),
    .md_busy    (md_busy),
    .stall      (stall)
  );

  task automatic ck(input string tag, input logic [12:0] exp);
    #1;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0;
    d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
    d_is_md = 1'b0;
    e_a3 = 5'd0; e_reg_wen = 1'b0; e_tnew = 2'd0;
    m_a3 = 5'd0; m_reg_wen = 1'b0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_op = 3'd0;
    m_dm_req = 1'b0; m_dm_ack = 1'b0;
    exc_req = 1'b0; m_eret = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    e_md_start = 1'b1;
    ck("rst", V_RST);
    tick();
    tick();
    reset = 1'b0;
    idle();
    ck("idle", V_NRM);

    // E-stage load-use on rs, then producer catches up
    e_reg_wen = 1'b1; e_a3 = 5'd8; e_tnew = 2'd2;
    d_rs_addr = 5'd8; d_rs_tuse = 2'd1;
    ck("ld_use", V_HZ);
    tick();
    e_tnew = 2'd1;
    ck("ld_use_rel", V_NRM);
    e_tnew = 2'd2; e_a3 = 5'd0; d_rs_addr = 5'd0;
    ck("zero_reg", V_NRM);
    tick();
    idle();

    // M-stage producer on rt, tuse boundaries
    m_reg_wen = 1'b1; m_a3 = 5'd5; m_tnew = 2'd1;
    d_rt_addr = 5'd5; d_rt_tuse = 2'd0;
    ck("m_rt_hz", V_HZ);
    d_rt_tuse = 2'd3;
    ck("rt_unused", V_NRM);
    d_rt_tuse = 2'd1;
    ck("tnew_eq_tuse", V_NRM);
    tick();
    idle();

    // div: start cycle + 10 busy cycles stall an md instruction
    e_md_start = 1'b1; e_md_op = 3'd2; d_is_md = 1'b1;
    ck("div_start", V_HZB);
    tick();
    e_md_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ck($sformatf("div_busy%0d", i), V_HZB);
      tick();
    end
    ck("div_done", V_NRM);
    tick();

    // mult: busy without an md consumer does not stall
    e_md_start = 1'b1; e_md_op = 3'd1; d_is_md = 1'b0;
    ck("mul_start", V_NRMB);
    tick();
    e_md_start = 1'b0; d_is_md = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ck($sformatf("mul_busy%0d", i), V_HZB);
      tick();
    end
    ck("mul_done", V_NRM);
    tick();
    idle();

    // memory wait: 3 cycles without ack, then ack
    m_dm_req = 1'b1; m_dm_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ck($sformatf("memwait%0d", i), V_MEM);
      tick();
    end
    m_dm_ack = 1'b1;
    ck("mem_ack", V_NRM);
    tick();
    m_dm_req = 1'b0; m_dm_ack = 1'b0;
    ck("mem_run", V_NRM);
    m_dm_req = 1'b1; m_dm_ack = 1'b1;
    ck("mem_fast_ack", V_NRM);
    tick();
    m_dm_req = 1'b0; m_dm_ack = 1'b0;
    ck("mem_fast_run", V_NRM);

    // exception during MEMWAIT with load-use pending
    e_md_start = 1'b1; e_md_op = 3'd2;
    tick();
    e_md_start = 1'b0;
    m_dm_req = 1'b1;
    ck("pre_exc_mem", V_MEMB);
    tick();
    exc_req = 1'b1;
    e_reg_wen = 1'b1; e_a3 = 5'd9; e_tnew = 2'd2;
    d_rs_addr = 5'd9; d_rs_tuse = 2'd0;
    ck("exc", V_EXCB);
    tick();
    idle();
    ck("post_exc_run", V_NRMB);
    tick();
    m_eret = 1'b1;
    ck("eret", V_ERTB);
    exc_req = 1'b1;
    ck("exc_eret", V_EXCB);
    tick();
    idle();
    tick();

    // reset with cnt=7 and MEMWAIT
    e_md_start = 1'b1; e_md_op = 3'd3;
    tick();
    e_md_start = 1'b0;
    tick();
    tick();
    m_dm_req = 1'b1;
    ck("pre_rst_mem", V_MEMB);
    tick();
    ck("pre_rst_wait", V_MEMB);
    reset = 1'b1;
    ck("mid_rst", V_RST);
    tick();
    reset = 1'b0;
    idle();
    ck("post_rst", V_NRM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the en/clr inputs of the four pipeline-register instances (F/D, D/E, E/M, M/W) and the PC enable.
- Combines load-use/Tnew-Tuse data-hazard detection, a mult/div busy counter, a data-memory wait handshake and exception/eret flush sequencing into one prioritised decision per cycle.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start
- DIV_CYC, 10, busy cycles after a div/divu start
- CNT_W, 4, width of the busy counter; must hold DIV_CYC

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_rs_addr  in  5  rs of the D-stage instruction
- d_rt_addr  in  5  rt of the D-stage instruction
- d_rs_tuse  in  2  cycles until D needs rs; 3 = unused
- d_rt_tuse  in  2  cycles until D needs rt; 3 = unused
- d_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_a3  in  5  E-stage destination register
- e_reg_wen  in  1  E-stage register write enable
- e_tnew  in  2  cycles until the E result is forwardable
- m_a3  in  5  M-stage destination register
- m_reg_wen  in  1  M-stage register write enable
- m_tnew  in  2  cycles until the M result is forwardable
- e_md_start  in  1  E-stage mult/div start pulse
- e_md_op  in  3  E-stage md op: 0 mult, 1 multu, 2 div, 3 divu
- m_dm_req  in  1  M-stage load/store access request
- m_dm_ack  in  1  data memory ready/ack
- exc_req  in  1  exception/interrupt taken at M
- m_eret  in  1  eret in M
- pc_en  out  1  PC register update enable
- pc_sel  out  2  0 sequential/branch, 1 handler vector, 2 EPC
- en_fd, en_de, en_em, en_mw  out  1 each  pipeline register enables
- clr_fd, clr_de, clr_em, clr_mw  out  1 each  pipeline register flushes
- md_busy  out  1  mult/div unit busy
- stall  out  1  any stall condition active this cycle

Behaviour:
- State register st ∈ {RUN, MEMWAIT}, plus busy counter cnt[CNT_W-1:0]; all other outputs are combinational from st, cnt and the inputs.
- Reset: st=RUN, cnt=0. While reset=1:
  - all clr_*=1, all en_*=1;
  - pc_en=0, pc_sel=0;
  - md_busy=0, stall=0.
- Mid-operation reset aborts MEMWAIT and clears cnt in the same edge.
- Data hazard, evaluated separately for each operand X ∈ {rs, rt}:
  - hz_X = (addr≠0) & (tuse_X≠3) & ((e_reg_wen & e_a3==addr & e_tnew>tuse_X) | (m_reg_wen & m_a3==addr & m_tnew>tuse_X)).
- md stall: md_hz = d_is_md & (cnt≠0 | e_md_start).
- md_busy = (cnt≠0) | e_md_start.
- Busy counter:
  - e_md_start with op 0/1 loads cnt=MULT_CYC; op 2/3 loads cnt=DIV_CYC.
  - Otherwise, cnt≠0 decrements by 1 per cycle.
  - A start while cnt≠0 reloads the counter.
  - The counter is not cleared by exception flush; an issued md op completes.
- Memory wait:
  - In RUN, m_dm_req & ~m_dm_ack moves st to MEMWAIT.
  - In MEMWAIT, m_dm_ack returns st to RUN; ack is consumed in that cycle.
  - A request with same-cycle ack never enters MEMWAIT.
- Priority, highest first; exactly one row applies per cycle:
  1. exc_req: clr_fd=clr_de=clr_em=1, en_mw=1, pc_en=1, pc_sel=1, st←RUN.
  2. m_eret: clr_fd=clr_de=clr_em=1, en_mw=1, pc_en=1, pc_sel=2.
  3. mem wait (st==MEMWAIT & ~m_dm_ack, or RUN & m_dm_req & ~m_dm_ack): en_fd=en_de=en_em=0, pc_en=0, clr_mw=1 (bubble into W), stall=1.
  4. data/md hazard (hz_rs|hz_rt|md_hz): en_fd=0, pc_en=0, clr_de=1, stall=1; E/M/W advance.
  5. normal: all en_*=1, all clr_*=0, pc_en=1, pc_sel=0.
- Defaults for every unlisted output in a row: en_*=1, clr_*=0, stall=0.
- clr has priority over en inside the pipeline registers, so a row asserting clr may leave en=1.
- exc_req and m_eret together: exc_req wins.

Decomposition:
- Shared package pipe_pkg holds:
  - TUSE_NONE=2'd3;
  - MD op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - PC_SEL_SEQ/EXC/EPC;
  - state enum {ST_RUN, ST_MEMWAIT}.
- One natural sub-module: md_busy_cnt (counter, load/decrement, busy output).

Test Plan:
- Load-use: e_reg_wen=1, e_a3=8, e_tnew=2, d_rs_addr=8, d_rs_tuse=1 → stall=1, en_fd=0, pc_en=0, clr_de=1; next cycle e_tnew=1 → no stall.
- Zero register: same as above but e_a3=0, d_rs_addr=0 → stall=0.
- Div busy: e_md_start=1, e_md_op=2, then d_is_md=1 held → stall for 11 cycles (start cycle + 10), released when cnt reaches 0. Mult gives 6 stall cycles.
- Memory wait: m_dm_req=1, m_dm_ack low for 3 cycles → en_fd/de/em=0 and clr_mw=1 for 3 cycles; ack cycle → all enables 1, st=RUN.
- Exception during MEMWAIT with concurrent load-use: exc_req=1 → clr_fd/de/em=1, pc_sel=1, pc_en=1, st→RUN next cycle; cnt unaffected.
- Reset asserted while cnt=7 and st=MEMWAIT → cnt=0, st=RUN after the edge; all clr_*=1 during reset.
